hls_macc_vec_locked: RTL and testbench
======================================

HLS_MACC_VEC_LOCKED -- requirements
Module: hls_macc_vec_locked

Interface
REQ-001 Parameter DATA_W, default 16: signed operand width per lane.
REQ-002 Parameter ACC_W, default 40: signed accumulator width per lane; ACC_W >= 2*DATA_W.
REQ-003 Parameter LANES, default 4: independent MAC lanes.
REQ-004 Parameter COUNT_W, default 8: width of the job length.
REQ-005 Parameter KEY_W, default 12: locking key width; KEY_W >= 4.
REQ-006 ap_clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 ap_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 ap_start  in  1  job request; sampled only in IDLE.
REQ-009 ap_done  out  1  one-cycle pulse; job complete.
REQ-010 ap_idle  out  1  high in IDLE.
REQ-011 ap_ready  out  1  one-cycle pulse, coincident with ap_done.
REQ-012 len  in  COUNT_W  samples per job; latched at start.
REQ-013 sat_en  in  1  1 = saturating accumulate, 0 = wrap; latched at start.
REQ-014 in_a  in  LANES*DATA_W  lane operands A; lane k at bits [k*DATA_W +: DATA_W].
REQ-015 in_b  in  LANES*DATA_W  lane operands B; same packing.
REQ-016 in_valid  in  1  sample present.
REQ-017 in_ready  out  1  sample accepted when in_valid & in_ready.
REQ-018 out_acc  out  LANES*ACC_W  lane results; lane k at bits [k*ACC_W +: ACC_W].
REQ-019 out_acc_ap_vld  out  1  out_acc valid; coincident with ap_done.
REQ-020 locking_key  in  KEY_W  key; working_key = locking_key[3:0]; bits above 3 ignored.

Function
REQ-021 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-022 IDLE: ap_start=1 latches len and sat_en, clears all accumulators and the sample counter, then goes to RUN, or to DONE if len=0.
REQ-023 RUN: in_ready=1; each accepted sample loads all LANES products into the stage-1 register and increments the counter.
REQ-024 RUN exit after the len-th accept: working_key[0]=1 -> DRAIN; working_key[0]=0 -> DONE (last stage-1 product is never accumulated).
REQ-025 DRAIN: lasts exactly one cycle, in_ready=0; the final stage-1 product is accumulated, then -> DONE.
REQ-026 DONE: lasts one cycle; ap_done=ap_ready=out_acc_ap_vld=1, in_ready=0; then -> IDLE.
REQ-027 Pipeline: stage 1 registers p = working_key[1] ? a*b : sext(a)+sext(b), signed.
REQ-028 Stage 2 registers acc' = working_key[2] ? acc+p : acc-p, in ACC_W+1 bits.
REQ-029 sat_en=1: acc' is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; sat_en=0: wraps modulo 2^ACC_W.
REQ-030 out_acc = working_key[3] ? acc : acc>>>1 (arithmetic shift); it holds its value outside DONE.
REQ-031 Correct key: working_key=4'hF; any other key gives deterministic, X-free, wrong results.
REQ-032 in_valid gaps in RUN stall the counter and insert no product; the result is unaffected.
REQ-033 ap_start outside IDLE is ignored; len and sat_en changes mid-job have no effect.
REQ-034 With continuous in_valid and len>0, ap_done asserts len+2 cycles after ap_start is sampled.
REQ-035 The counter compares at COUNT_W bits and never wraps; len=2^COUNT_W-1 is legal.

Reset
REQ-036 Reset asserted: state=IDLE, counter, stage-1 and stage-2 registers and out_acc=0, ap_done=ap_ready=out_acc_ap_vld=in_ready=0, ap_idle=1.
REQ-037 Reset asserted mid-job aborts the job with no done pulse; the next job after release is correct.

Verification
REQ-038 Key 0xF, len=3, lane0 a=2,3,4 b=5,6,7, continuous valid -> ap_done 5 cycles after start, lane0=56.
REQ-039 ACC_W=32, sat_en=1, len=4, a=b=-32768 -> 2147483647; same with sat_en=0 -> 0.
REQ-040 Scenario REQ-038 with one idle cycle between samples -> lane0=56, ap_done 6 cycles after start.
REQ-041 Scenario REQ-038 with key 0xE -> 28; key 0xD -> 27; key 0x7 -> 28.
REQ-042 len=0 -> ap_done 1 cycle after start, all lanes 0.
REQ-043 Reset asserted in RUN at sample 2 -> ap_idle=1 and out_acc=0 immediately; a rerun of REQ-038 -> 56.

Source files
------------

// File: rtl/hls_macc_vec_locked_if.sv
// Job control, sample stream and result bus between a job master and hls_macc_vec_locked.
interface hls_macc_vec_locked_if #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int LANES   = 4,
    parameter int COUNT_W = 8,
    parameter int KEY_W   = 12
);
    logic                     ap_start;
    logic                     ap_done;
    logic                     ap_idle;
    logic                     ap_ready;
    logic [COUNT_W-1:0]       len;
    logic                     sat_en;
    logic [LANES*DATA_W-1:0]  in_a;
    logic [LANES*DATA_W-1:0]  in_b;
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*ACC_W-1:0]   out_acc;
    logic                     out_acc_ap_vld;
    logic [KEY_W-1:0]         locking_key;

    modport master (
        output ap_start, len, sat_en, in_a, in_b, in_valid, locking_key,
        input  ap_done, ap_idle, ap_ready, in_ready, out_acc, out_acc_ap_vld
    );

    modport slave (
        input  ap_start, len, sat_en, in_a, in_b, in_valid, locking_key,
        output ap_done, ap_idle, ap_ready, in_ready, out_acc, out_acc_ap_vld
    );
endinterface

// File: rtl/hls_macc_vec_locked.sv
// Purpose: LANES-wide keyed multiply/add accumulator; one job of len samples per ap_start.
// Latency: ap_done len+2 cycles after start with gapless input, 1 cycle when len=0.
// Backpressure: in_ready high only in RUN; in_valid gaps stall the job without side effects.
module hls_macc_vec_locked #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int LANES   = 4,
    parameter int COUNT_W = 8,
    parameter int KEY_W   = 12
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    hls_macc_vec_locked_if.slave  bus
);
    localparam int P_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [COUNT_W-1:0]      len_q, cnt_q;
    logic                    sat_q, p_vld_q;
    logic [3:0]              wkey;
    logic                    start_go, accept, last_accept, acc_en;
    logic [LANES*ACC_W-1:0]  out_q;

    logic signed [P_W-1:0]   a_ext   [LANES];
    logic signed [P_W-1:0]   b_ext   [LANES];
    logic signed [P_W-1:0]   p_d     [LANES];
    logic signed [P_W-1:0]   p_q     [LANES];
    logic signed [ACC_W:0]   sum_w   [LANES];
    logic signed [ACC_W-1:0] acc_new [LANES];
    logic signed [ACC_W-1:0] acc_d   [LANES];
    logic signed [ACC_W-1:0] acc_q   [LANES];
    logic signed [ACC_W-1:0] out_d   [LANES];

    // The key is live, not latched: only its low nibble steers the datapath.
    assign wkey = bus.locking_key[3:0];

    if (KEY_W > 4) begin : g_key_pad
        logic key_unused;
        assign key_unused = ^bus.locking_key[KEY_W-1:4];
    end

    assign start_go    = (state_q == S_IDLE) && bus.ap_start;
    assign accept      = (state_q == S_RUN) && bus.in_valid;
    assign last_accept = accept && (cnt_q == len_q - COUNT_W'(1));
    assign acc_en      = p_vld_q && (accept || (state_q == S_DRAIN));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.ap_start) state_d = (bus.len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (last_accept) state_d = wkey[0] ? S_DRAIN : S_DONE;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            a_ext[k] = {{DATA_W{bus.in_a[k*DATA_W+DATA_W-1]}}, bus.in_a[k*DATA_W +: DATA_W]};
            b_ext[k] = {{DATA_W{bus.in_b[k*DATA_W+DATA_W-1]}}, bus.in_b[k*DATA_W +: DATA_W]};
            p_d[k]   = wkey[1] ? (a_ext[k] * b_ext[k]) : (a_ext[k] + b_ext[k]);
            sum_w[k] = wkey[2]
                     ? ({acc_q[k][ACC_W-1], acc_q[k]} + {{(ACC_W+1-P_W){p_q[k][P_W-1]}}, p_q[k]})
                     : ({acc_q[k][ACC_W-1], acc_q[k]} - {{(ACC_W+1-P_W){p_q[k][P_W-1]}}, p_q[k]});
            // Top two bits disagree only when the ACC_W+1 result left the ACC_W range.
            if (sat_q && (sum_w[k][ACC_W] != sum_w[k][ACC_W-1]))
                acc_new[k] = sum_w[k][ACC_W] ? ACC_MIN : ACC_MAX;
            else
                acc_new[k] = sum_w[k][ACC_W-1:0];
            acc_d[k] = start_go ? '0 : (acc_en ? acc_new[k] : acc_q[k]);
            out_d[k] = wkey[3] ? acc_d[k] : (acc_d[k] >>> 1);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            p_vld_q <= 1'b0;
            out_q   <= '0;
            for (int k = 0; k < LANES; k++) begin
                p_q[k]   <= '0;
                acc_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (start_go) begin
                len_q   <= bus.len;
                sat_q   <= bus.sat_en;
                cnt_q   <= '0;
                p_vld_q <= 1'b0;
            end
            if (accept) begin
                cnt_q   <= cnt_q + COUNT_W'(1);
                p_vld_q <= 1'b1;
                for (int k = 0; k < LANES; k++) p_q[k] <= p_d[k];
            end
            for (int k = 0; k < LANES; k++) acc_q[k] <= acc_d[k];
            // Result is captured on DONE entry from the final accumulator value.
            if (state_d == S_DONE && state_q != S_DONE)
                for (int k = 0; k < LANES; k++) out_q[k*ACC_W +: ACC_W] <= out_d[k];
        end
    end

    assign bus.ap_idle        = (state_q == S_IDLE);
    assign bus.ap_done        = (state_q == S_DONE);
    assign bus.ap_ready       = (state_q == S_DONE);
    assign bus.out_acc_ap_vld = (state_q == S_DONE);
    assign bus.in_ready       = (state_q == S_RUN);
    assign bus.out_acc        = out_q;
endmodule

// File: tb/tb_hls_macc_vec_locked.sv
// Randomized bench for hls_macc_vec_locked against an arithmetic per-lane reference model.
module tb_hls_macc_vec_locked;
    localparam int DATA_W  = 16;
    localparam int ACC_W   = 32;
    localparam int LANES   = 4;
    localparam int COUNT_W = 8;
    localparam int KEY_W   = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hls_macc_vec_locked_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES),
                             .COUNT_W(COUNT_W), .KEY_W(KEY_W)) bus ();

    hls_macc_vec_locked #(.DATA_W(DATA_W), .ACC_W(ACC_W), .LANES(LANES),
                          .COUNT_W(COUNT_W), .KEY_W(KEY_W)) dut (
        .ap_clk   (clk),
        .ap_rst_n (rst_n),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int sa [256][LANES];
    int sb [256][LANES];

    task automatic check(input string tag, input longint got, input longint exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane_out(input int k);
        return longint'($signed(bus.out_acc[k*ACC_W +: ACC_W]));
    endfunction

    // Reference: straight accumulation over the samples that the key lets through.
    function automatic longint model(input int k, input int n, input bit sat, input logic [3:0] key);
        longint acc, p, amax, amin, span;
        int use_n;
        acc  = 0;
        amax = (longint'(1) <<< (ACC_W - 1)) - 1;
        amin = -amax - 1;
        span = longint'(1) <<< ACC_W;
        use_n = (n == 0) ? 0 : (key[0] ? n : n - 1);
        for (int i = 0; i < use_n; i++) begin
            p   = key[1] ? longint'(sa[i][k]) * longint'(sb[i][k]) : longint'(sa[i][k] + sb[i][k]);
            acc = key[2] ? acc + p : acc - p;
            if (sat) begin
                if (acc > amax) acc = amax;
                if (acc < amin) acc = amin;
            end else begin
                acc = acc % span;
                if (acc > amax) acc = acc - span;
                if (acc < amin) acc = acc + span;
            end
        end
        return key[3] ? acc : (acc >>> 1);
    endfunction

    function automatic int rnd_val();
        if ($urandom_range(0, 3) == 0)
            return ($urandom_range(0, 1) == 1) ? -32768 : 32767;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < LANES; k++) begin
                sa[i][k] = rnd_val();
                sb[i][k] = rnd_val();
            end
    endtask

    task automatic drive(input bit vld, input int idx);
        bus.in_valid = vld;
        for (int k = 0; k < LANES; k++) begin
            if (vld) begin
                bus.in_a[k*DATA_W +: DATA_W] = DATA_W'(sa[idx][k]);
                bus.in_b[k*DATA_W +: DATA_W] = DATA_W'(sb[idx][k]);
            end else begin
                bus.in_a[k*DATA_W +: DATA_W] = DATA_W'($urandom);
                bus.in_b[k*DATA_W +: DATA_W] = DATA_W'($urandom);
            end
        end
    endtask

    task automatic start_job(input int n, input bit sat, input logic [3:0] key);
        logic [KEY_W-1:0] kk;
        @(negedge clk);
        kk = KEY_W'($urandom);
        kk[3:0] = key;
        bus.len = COUNT_W'(n);
        bus.sat_en = sat;
        bus.locking_key = kk;
        bus.ap_start = 1'b1;
        drive(1'b0, 0);
        @(posedge clk);
        #1;
        bus.ap_start = 1'b0;
        bus.len = COUNT_W'($urandom);
        bus.sat_en = ~sat;
    endtask

    task automatic run_job(input string tag, input int n, input bit sat, input logic [3:0] key,
                           input int gap_at, input int gap_pct, input int exp_cyc);
        int cycles, idx;
        bit gapped, done, vld;
        longint e0;
        start_job(n, sat, key);
        cycles = 1;
        idx = 0;
        gapped = 0;
        done = 0;
        while (cycles < 2000) begin
            if (bus.ap_done) begin
                done = 1;
                break;
            end
            vld = 0;
            if (idx < n) begin
                if (idx == gap_at && !gapped) gapped = 1;
                else if ($urandom_range(0, 99) >= gap_pct) vld = 1;
            end
            drive(vld, idx);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            @(posedge clk);
            #1;
            cycles++;
        end
        drive(1'b0, 0);
        check({tag, "/done_seen"}, done, 1);
        if (exp_cyc >= 0) check({tag, "/latency"}, cycles, exp_cyc);
        check({tag, "/ready"}, bus.ap_ready, 1);
        check({tag, "/out_vld"}, bus.out_acc_ap_vld, 1);
        check({tag, "/in_ready_done"}, bus.in_ready, 0);
        check({tag, "/consumed"}, idx, n);
        for (int k = 0; k < LANES; k++)
            check($sformatf("%s/lane%0d", tag, k), lane_out(k), model(k, n, sat, key));
        e0 = model(0, n, sat, key);
        @(posedge clk);
        #1;
        check({tag, "/done_pulse"}, bus.ap_done, 0);
        check({tag, "/idle_after"}, bus.ap_idle, 1);
        check({tag, "/hold"}, lane_out(0), e0);
    endtask

    task automatic load_req038();
        fill_random(3);
        sa[0][0] = 2; sa[1][0] = 3; sa[2][0] = 4;
        sb[0][0] = 5; sb[1][0] = 6; sb[2][0] = 7;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] key;
        bus.ap_start = 1'b0;
        bus.len = '0;
        bus.sat_en = 1'b0;
        bus.locking_key = '1;
        drive(1'b0, 0);

        #12;
        check("rst/idle", bus.ap_idle, 1);
        check("rst/done", bus.ap_done, 0);
        check("rst/ready", bus.ap_ready, 0);
        check("rst/out_vld", bus.out_acc_ap_vld, 0);
        check("rst/in_ready", bus.in_ready, 0);
        check("rst/out_acc", (bus.out_acc == '0), 1);
        @(negedge clk);
        rst_n = 1'b1;

        load_req038();
        run_job("req038", 3, 1'b0, 4'hF, -1, 0, 5);
        check("req038/lit", lane_out(0), 56);
        run_job("req040", 3, 1'b0, 4'hF, 1, 0, 6);
        check("req040/lit", lane_out(0), 56);
        run_job("key_e", 3, 1'b0, 4'hE, -1, 0, 4);
        check("key_e/lit", lane_out(0), 28);
        run_job("key_d", 3, 1'b0, 4'hD, -1, 0, 5);
        check("key_d/lit", lane_out(0), 27);
        run_job("key_7", 3, 1'b0, 4'h7, -1, 0, 5);
        check("key_7/lit", lane_out(0), 28);

        for (int i = 0; i < 4; i++)
            for (int k = 0; k < LANES; k++) begin
                sa[i][k] = -32768;
                sb[i][k] = -32768;
            end
        run_job("sat_on", 4, 1'b1, 4'hF, -1, 0, 6);
        check("sat_on/lit", lane_out(0), 2147483647);
        run_job("sat_off", 4, 1'b0, 4'hF, -1, 0, 6);
        check("sat_off/lit", lane_out(0), 0);

        run_job("len0", 0, 1'b0, 4'hF, -1, 0, 1);
        check("len0/lit", lane_out(3), 0);

        // Abort in RUN after two accepted samples; a nonzero previous result must be cleared.
        load_req038();
        run_job("pre_abort", 3, 1'b0, 4'hF, -1, 0, 5);
        start_job(3, 1'b0, 4'hF);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, i);
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort/idle", bus.ap_idle, 1);
        check("abort/out_acc", (bus.out_acc == '0), 1);
        check("abort/in_ready", bus.in_ready, 0);
        drive(1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("abort/no_done", bus.ap_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_job("rerun", 3, 1'b0, 4'hF, -1, 0, 5);
        check("rerun/lit", lane_out(0), 56);

        fill_random(255);
        run_job("len255_sat", 255, 1'b1, 4'hF, -1, 0, 257);
        run_job("len255_wrap", 255, 1'b0, 4'hF, -1, 0, 257);

        for (int j = 0; j < 24; j++) begin
            n = $urandom_range(0, 20);
            key = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            fill_random(n);
            run_job($sformatf("rnd%0d", j), n, 1'($urandom), key, -1, $urandom_range(0, 30), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
